// File: rtl/bfly_ingress_if.sv
// Source/channel bundle for one butterfly ingress port.
// Handshake: a word moves from source to port on a rising clk edge where
// s_valid and s_ready are both high; s_ready never depends on s_valid.
interface bfly_ingress_if #(
  parameter int DEST_W        = 6,
  parameter int CHANNEL_WIDTH = 18
);
  logic                     s_valid;
  logic                     s_ready;
  logic [15:0]              s_data;
  logic [DEST_W-1:0]        s_dest;
  logic                     s_last;
  logic                     ch_stall;
  logic [CHANNEL_WIDTH-1:0] out_ch;
  logic [15:0]              pkt_sent;
  logic                     dbg_state;  // output FSM: 0 = IDLE, 1 = BODY

  modport master (
    output s_valid, s_data, s_dest, s_last, ch_stall,
    input  s_ready, out_ch, pkt_sent, dbg_state
  );

  modport slave (
    input  s_valid, s_data, s_dest, s_last, ch_stall,
    output s_ready, out_ch, pkt_sent, dbg_state
  );
endinterface

// File: rtl/bfly_ingress_port.sv
// Per-port injection stage for the 64-port butterfly: buffers source words
// in a small FIFO and serialises each packet as head, body..., tail flits.
module bfly_ingress_port #(
  parameter int CHANNEL_WIDTH = 18,
  parameter int DEST_W        = 6,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic           clk,
  input  logic           rst,
  bfly_ingress_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DEST_W + 17;  // {dest, last, data}

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  logic [EW-1:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [CW-1:0]            count;
  logic                     in_pkt;
  logic [DEST_W-1:0]        dest_lat;
  state_t                   state;
  logic [CHANNEL_WIDTH-1:0] out_q;
  logic [15:0]              sent_q;

  logic                     full;
  logic                     empty;
  logic                     wr_en;
  logic                     rd_en;
  logic [DEST_W-1:0]        wr_dest;
  logic [EW-1:0]            head;
  logic [DEST_W-1:0]        head_dest;
  logic                     head_last;
  logic [15:0]              head_data;

  // Ready comes from the registered count only, so a full FIFO refuses a
  // write even in a cycle where it is also being read.
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = bus.s_valid && bus.s_ready;
  assign rd_en   = !bus.ch_stall && (state == ST_BODY) && !empty;
  assign wr_dest = in_pkt ? dest_lat : bus.s_dest;

  assign head      = mem[rd_ptr];
  assign head_dest = head[EW-1:17];
  assign head_last = head[16];
  assign head_data = head[15:0];

  assign bus.s_ready   = !rst && !full;
  assign bus.out_ch    = out_q;
  assign bus.pkt_sent  = sent_q;
  assign bus.dbg_state = state;

  // FIFO storage: contents need no reset, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {wr_dest, bus.s_last, bus.s_data};
  end

  // FIFO pointers/count and the source-side packet tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_pkt   <= 1'b0;
      dest_lat <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr   <= wr_ptr + 1'b1;
        dest_lat <= wr_dest;
        in_pkt   <= !bus.s_last;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output FSM: head is emitted from the peeked entry without popping,
  // then every non-empty BODY cycle pops one word; a stall freezes all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      out_q  <= '0;
      sent_q <= '0;
    end else if (!bus.ch_stall) begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            out_q <= {2'b01, {(16-DEST_W){1'b0}}, head_dest};
            state <= ST_BODY;
          end else begin
            out_q <= '0;
          end
        end
        ST_BODY: begin
          if (!empty) begin
            out_q <= {(head_last ? 2'b11 : 2'b10), head_data};
            if (head_last) begin
              state  <= ST_IDLE;
              sent_q <= sent_q + 16'd1;
            end
          end else begin
            out_q <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          out_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bfly_ingress_port.sv
// Bench for bfly_ingress_port: directed scenarios followed by random traffic,
// every cycle compared against a queue-based packet model.
module tb_bfly_ingress_port;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bfly_ingress_if #(.DEST_W(6), .CHANNEL_WIDTH(18)) bus ();

  bfly_ingress_port #(
    .CHANNEL_WIDTH(18),
    .DEST_W       (6),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [22:0] exp_q[$];        // buffered words {dest, last, data}
  bit          m_head_done;     // head flit of the front packet already sent
  bit          m_src_in_pkt;    // source is mid-packet
  logic [5:0]  m_src_dest;
  logic [17:0] m_out;
  logic [15:0] m_sent;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock edge from the inputs presented at it.
  task automatic model_edge();
    bit          acc;
    logic [22:0] e;
    logic [5:0]  d;
    if (rst) begin
      exp_q.delete();
      m_head_done  = 0;
      m_src_in_pkt = 0;
      m_out        = '0;
      m_sent       = '0;
    end else begin
      acc = bus.s_valid && (exp_q.size() < DEPTH);
      if (!bus.ch_stall) begin
        if (exp_q.size() == 0) begin
          m_out = '0;
        end else if (!m_head_done) begin
          m_out = {2'b01, 10'd0, exp_q[0][22:17]};
          m_head_done = 1;
        end else begin
          e = exp_q.pop_front();
          m_out = {(e[16] ? 2'b11 : 2'b10), e[15:0]};
          if (e[16]) begin
            m_head_done = 0;
            m_sent = m_sent + 16'd1;
          end
        end
      end
      if (acc) begin
        d = m_src_in_pkt ? m_src_dest : bus.s_dest;
        exp_q.push_back({d, bus.s_last, bus.s_data});
        m_src_dest   = d;
        m_src_in_pkt = !bus.s_last;
      end
    end
  endtask

  // One clock: model update at the edge, DUT compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("out_ch", 32'(bus.out_ch), 32'(m_out));
    chk("pkt_sent", 32'(bus.pkt_sent), 32'(m_sent));
    chk("s_ready", 32'(bus.s_ready), 32'(!rst && (exp_q.size() < DEPTH)));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [5:0] dest, input logic [15:0] data,
                       input logic last);
    bus.s_valid = v;
    bus.s_dest  = dest;
    bus.s_data  = data;
    bus.s_last  = last;
  endtask

  initial begin
    bus.ch_stall = 1'b0;
    drive(1'b0, 6'd0, 16'h0, 1'b0);

    // 1: reset held two cycles, then released
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_ch", 32'(bus.out_ch), 32'h0);
    chk("rst_pkt_sent", 32'(bus.pkt_sent), 32'h0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bus.s_ready), 32'h1);

    // 2: single-word packet
    drive(1'b1, 6'd5, 16'hABCD, 1'b1);
    tick();
    drive(1'b0, 6'd0, 16'h0, 1'b0);
    tick();
    chk("single_head", 32'(bus.out_ch), 32'h10005);
    tick();
    chk("single_tail", 32'(bus.out_ch), 32'h3ABCD);
    chk("single_sent", 32'(bus.pkt_sent), 32'd1);
    tick();
    chk("single_idle", 32'(bus.out_ch), 32'h0);

    // 3: three-word packet to port 63; later s_dest values must be ignored
    drive(1'b1, 6'd63, 16'd1, 1'b0);
    tick();
    drive(1'b1, 6'($urandom_range(0, 62)), 16'd2, 1'b0);
    tick();
    chk("p3_head", 32'(bus.out_ch), 32'h1003F);
    drive(1'b1, 6'($urandom_range(0, 62)), 16'd3, 1'b1);
    tick();
    chk("p3_body1", 32'(bus.out_ch), 32'h20001);
    drive(1'b0, 6'd0, 16'h0, 1'b0);
    tick();
    chk("p3_body2", 32'(bus.out_ch), 32'h20002);
    tick();
    chk("p3_tail", 32'(bus.out_ch), 32'h30003);
    tick();
    chk("p3_idle", 32'(bus.out_ch), 32'h0);
    chk("p3_sent", 32'(bus.pkt_sent), 32'd2);

    // 4: stall while nine words are offered; only eight fit
    bus.ch_stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 6'd17, 16'h0400 + 16'(i), (i == 7));
      tick();
      chk("stall_out_ch", 32'(bus.out_ch), 32'h0);
    end
    chk("stall_full_ready", 32'(bus.s_ready), 32'h0);
    drive(1'b0, 6'd0, 16'h0, 1'b0);
    bus.ch_stall = 1'b0;
    tick();
    chk("stall_head", 32'(bus.out_ch), 32'h10011);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stall_word", 32'(bus.out_ch), {14'd0, (i == 7) ? 2'b11 : 2'b10, 16'h0400 + 16'(i)});
    end
    tick();

    // 5: source gap mid-packet
    drive(1'b1, 6'd9, 16'h0051, 1'b0);
    tick();
    drive(1'b0, 6'd0, 16'h0, 1'b0);
    tick();
    chk("gap_head", 32'(bus.out_ch), 32'h10009);
    tick();
    chk("gap_body", 32'(bus.out_ch), 32'h20051);
    tick();
    chk("gap_bubble", 32'(bus.out_ch), 32'h0);
    chk("gap_state", 32'(bus.dbg_state), 32'h1);
    drive(1'b1, 6'd40, 16'h0052, 1'b1);
    tick();
    chk("gap_bubble2", 32'(bus.out_ch), 32'h0);
    drive(1'b0, 6'd0, 16'h0, 1'b0);
    tick();
    chk("gap_tail", 32'(bus.out_ch), 32'h30052);
    tick();

    // 6: reset between head and tail drops the packet
    drive(1'b1, 6'd2, 16'h0061, 1'b0);
    tick();
    drive(1'b0, 6'd0, 16'h0, 1'b0);
    tick();
    chk("rstmid_head", 32'(bus.out_ch), 32'h10002);
    rst = 1'b1;
    tick();
    chk("rstmid_out_ch", 32'(bus.out_ch), 32'h0);
    chk("rstmid_sent", 32'(bus.pkt_sent), 32'h0);
    rst = 1'b0;
    tick();
    tick();
    chk("rstmid_empty", 32'(bus.out_ch), 32'h0);
    drive(1'b1, 6'd7, 16'h0071, 1'b1);
    tick();
    drive(1'b0, 6'd0, 16'h0, 1'b0);
    tick();
    chk("rstmid_next_head", 32'(bus.out_ch), 32'h10007);
    tick();
    chk("rstmid_next_tail", 32'(bus.out_ch), 32'h30071);

    // Random traffic with stalls and rare resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.ch_stall = ($urandom_range(0, 3) == 0);
      drive(($urandom_range(0, 2) != 0), 6'($urandom), 16'($urandom),
            ($urandom_range(0, 3) == 0));
      tick();
    end
    rst = 1'b0;
    bus.ch_stall = 1'b0;
    drive(1'b0, 6'd0, 16'h0, 1'b0);
    for (int i = 0; i < 20; i++) tick();

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
